branch_redirect_ctrl: RTL and testbench

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

---
 rtl/branch_redirect_ctrl.sv | 117 +++++++++++
 tb/tb_branch_redirect_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Decode-stage branch/jump redirect controller: stalls on operand hazards,
// then redirects the PC and flushes IF/ID for taken branches and jumps.
module branch_redirect_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch,
  input  logic             jump,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic             busy,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {IDLE, STALL, REDIRECT} state_t;

  state_t     state, state_nxt;
  logic [1:0] stall_cnt, stall_cnt_nxt;
  logic [1:0] hazard_cnt;
  logic       ex_match, mem_match, cond_branch, capture;

  // Register 0 is hardwired, so a zero destination never creates a dependency.
  assign ex_match    = (ex_rd != 5'd0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
  assign mem_match   = (mem_rd != 5'd0) && ((mem_rd == id_rs) || (mem_rd == id_rt));
  assign cond_branch = branch && !jump;

  always_comb begin
    hazard_cnt = 2'd0;
    if (cond_branch && ex_regwrite && ex_match) begin
      hazard_cnt = ex_memread ? 2'd2 : 2'd1;
    end else if (cond_branch && mem_memread && mem_match) begin
      hazard_cnt = 2'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    capture       = 1'b0;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    pc_sel        = 1'b0;
    // While reset is held the outputs stay pass-through regardless of inputs.
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (hazard_cnt != 2'd0) begin
            state_nxt     = STALL;
            stall_cnt_nxt = hazard_cnt;
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            idex_bubble   = 1'b1;
          end else if (jump || (branch && branch_taken)) begin
            state_nxt   = REDIRECT;
            capture     = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        STALL: begin
          pc_write      = 1'b0;
          ifid_write    = 1'b0;
          idex_bubble   = 1'b1;
          stall_cnt_nxt = stall_cnt - 2'd1;
          if (stall_cnt <= 2'd1) begin
            state_nxt     = IDLE;
            stall_cnt_nxt = 2'd0;
          end
        end
        REDIRECT: begin
          pc_sel     = 1'b1;
          ifid_flush = 1'b1;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      stall_cnt      <= 2'd0;
      pc_target      <= 32'd0;
      redirect_count <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
      if (capture) begin
        pc_target <= branch_target;
      end
      if (state == REDIRECT) begin
        redirect_count <= redirect_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model; a narrow-counter copy checks wrap.
module tb_branch_redirect_ctrl;

  logic        clk, rst_n;
  logic        branch, jump, branch_taken;
  logic [31:0] branch_target;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        ex_regwrite, ex_memread, mem_memread;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble, pc_sel, busy;
  logic [31:0] pc_target;
  logic [15:0] redirect_count;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_pc_sel, s_busy;
  logic [31:0] s_pc_target;
  logic [3:0]  s_redirect_count;

  logic [4:0]  ctl;
  localparam logic [4:0] PASS = 5'b11000;
  localparam logic [4:0] FRZ  = 5'b00010;
  localparam logic [4:0] RED  = 5'b11101;
  assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, pc_sel};

  int vectors = 0;
  int miscompares = 0;

  branch_redirect_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .jump(jump), .branch_taken(branch_taken),
    .branch_target(branch_target), .id_rs(id_rs), .id_rt(id_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_memread(mem_memread), .mem_rd(mem_rd),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pc_sel(pc_sel), .pc_target(pc_target),
    .busy(busy), .redirect_count(redirect_count)
  );

  branch_redirect_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .branch(branch), .jump(jump), .branch_taken(branch_taken),
    .branch_target(branch_target), .id_rs(id_rs), .id_rt(id_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_memread(mem_memread), .mem_rd(mem_rd),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .pc_sel(s_pc_sel), .pc_target(s_pc_target),
    .busy(s_busy), .redirect_count(s_redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Behavioural model: pending stall cycles, a pending redirect, captured target, event count.
  int          m_stall_left, n_stall_left;
  bit          m_redir, n_redir;
  logic [31:0] m_target, n_target;
  int unsigned m_count, n_count;
  logic [4:0]  e_ctl;
  bit          e_busy;

  function automatic int model_hazard();
    bit ex_hit, mem_hit;
    if (jump || !branch) return 0;
    ex_hit  = (ex_rd != 0) && (ex_rd == id_rs || ex_rd == id_rt);
    mem_hit = (mem_rd != 0) && (mem_rd == id_rs || mem_rd == id_rt);
    if (ex_regwrite && ex_memread && ex_hit) return 2;
    if (ex_regwrite && ex_hit) return 1;
    if (mem_memread && mem_hit) return 1;
    return 0;
  endfunction

  function automatic void model_eval();
    int hz;
    n_stall_left = m_stall_left;
    n_redir      = m_redir;
    n_target     = m_target;
    n_count      = m_count;
    e_busy       = m_redir || (m_stall_left > 0);
    if (m_redir) begin
      e_ctl   = RED;
      n_redir = 1'b0;
      n_count = m_count + 1;
    end else if (m_stall_left > 0) begin
      e_ctl        = FRZ;
      n_stall_left = m_stall_left - 1;
    end else begin
      hz = model_hazard();
      if (hz > 0) begin
        e_ctl        = FRZ;
        n_stall_left = hz;
      end else if (jump || (branch && branch_taken)) begin
        e_ctl    = FRZ;
        n_target = branch_target;
        n_redir  = 1'b1;
      end else begin
        e_ctl = PASS;
      end
    end
  endfunction

  function automatic void model_reset();
    m_stall_left = 0;
    m_redir      = 1'b0;
    m_target     = 32'd0;
    m_count      = 0;
  endfunction

  task automatic set_idle();
    branch = 0; jump = 0; branch_taken = 0; branch_target = 32'd0;
    id_rs = 0; id_rt = 0; ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_memread = 0; mem_rd = 0;
  endtask

  // Advances one clock from a negedge to the next negedge, stepping the model.
  task automatic tick();
    model_eval();
    @(posedge clk);
    m_stall_left = n_stall_left;
    m_redir      = n_redir;
    m_target     = n_target;
    m_count      = n_count;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_idle();
    #1;
    vectors++; if (ctl !== PASS) begin miscompares++; $display("FAIL reset_ctl got=%b exp=%b", ctl, PASS); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (pc_target !== 32'd0) begin miscompares++; $display("FAIL reset_target got=%h exp=0", pc_target); end
    vectors++; if (redirect_count !== 16'd0) begin miscompares++; $display("FAIL reset_count got=%h exp=0", redirect_count); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_jump();
    test_reset();
    jump = 1; branch_target = 32'h0040_0040;
    #1;
    vectors++; if (ctl !== FRZ) begin miscompares++; $display("FAIL jump_decide_ctl got=%b exp=%b", ctl, FRZ); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL jump_decide_busy got=%b exp=0", busy); end
    tick();
    set_idle();
    #1;
    vectors++; if (ctl !== RED) begin miscompares++; $display("FAIL jump_redirect_ctl got=%b exp=%b", ctl, RED); end
    vectors++; if (pc_target !== 32'h0040_0040) begin miscompares++; $display("FAIL jump_target got=%h exp=00400040", pc_target); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL jump_redirect_busy got=%b exp=1", busy); end
    vectors++; if (redirect_count !== 16'd0) begin miscompares++; $display("FAIL jump_count_before got=%h exp=0", redirect_count); end
    tick();
    #1;
    vectors++; if (redirect_count !== 16'd1) begin miscompares++; $display("FAIL jump_count_after got=%h exp=1", redirect_count); end
    vectors++; if (ctl !== PASS || busy !== 1'b0) begin miscompares++; $display("FAIL jump_return_idle ctl=%b busy=%b exp=%b/0", ctl, busy, PASS); end
    vectors++; if (pc_target !== 32'h0040_0040) begin miscompares++; $display("FAIL jump_target_hold got=%h exp=00400040", pc_target); end
  endtask

  task automatic test_not_taken();
    test_reset();
    for (int i = 0; i < 4; i++) begin
      branch = 1; branch_taken = 0; branch_target = $urandom;
      id_rs = 5'($urandom_range(1, 31)); id_rt = 5'($urandom_range(1, 31));
      ex_rd = id_rs; ex_regwrite = 0; mem_rd = id_rt; mem_memread = 0;
      #1;
      vectors++; if (ctl !== PASS || busy !== 1'b0) begin miscompares++; $display("FAIL not_taken_ctl cyc=%0d ctl=%b busy=%b exp=%b/0", i, ctl, busy, PASS); end
      vectors++; if (redirect_count !== 16'd0) begin miscompares++; $display("FAIL not_taken_count got=%h exp=0", redirect_count); end
      tick();
    end
  endtask

  task automatic test_load_use();
    test_reset();
    branch = 1; branch_taken = 1; branch_target = 32'h1000_0020;
    id_rs = 8; id_rt = 3; ex_regwrite = 1; ex_memread = 1; ex_rd = 8;
    #1;
    vectors++; if (ctl !== FRZ || busy !== 1'b0) begin miscompares++; $display("FAIL load_use_decide ctl=%b busy=%b exp=%b/0", ctl, busy, FRZ); end
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if (ctl !== FRZ || busy !== 1'b1) begin miscompares++; $display("FAIL load_use_stall%0d ctl=%b busy=%b exp=%b/1", i, ctl, busy, FRZ); end
      tick();
    end
    ex_regwrite = 0; ex_memread = 0;
    #1;
    vectors++; if (ctl !== FRZ || busy !== 1'b0) begin miscompares++; $display("FAIL load_use_reeval ctl=%b busy=%b exp=%b/0", ctl, busy, FRZ); end
    tick();
    set_idle();
    #1;
    vectors++; if (ctl !== RED) begin miscompares++; $display("FAIL load_use_redirect got=%b exp=%b", ctl, RED); end
    vectors++; if (pc_target !== 32'h1000_0020) begin miscompares++; $display("FAIL load_use_target got=%h exp=10000020", pc_target); end
    tick();
  endtask

  task automatic test_zero_reg();
    test_reset();
    branch = 1; branch_taken = 1; branch_target = 32'h2000_0000;
    id_rs = 5; id_rt = 0; ex_rd = 0; ex_regwrite = 1; ex_memread = 1;
    mem_rd = 0; mem_memread = 1;
    #1;
    vectors++; if (ctl !== FRZ || busy !== 1'b0) begin miscompares++; $display("FAIL zero_reg_decide ctl=%b busy=%b exp=%b/0", ctl, busy, FRZ); end
    tick();
    set_idle();
    #1;
    vectors++; if (ctl !== RED || pc_target !== 32'h2000_0000) begin miscompares++; $display("FAIL zero_reg_redirect ctl=%b tgt=%h exp=%b/20000000", ctl, pc_target, RED); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    test_reset();
    jump = 1; branch_target = 32'hABCD_0000;
    tick();
    set_idle();
    tick();
    branch = 1; id_rs = 8; ex_regwrite = 1; ex_memread = 1; ex_rd = 8;
    tick();
    #1;
    vectors++; if (busy !== 1'b1 || redirect_count !== 16'd1) begin miscompares++; $display("FAIL mid_stall_pre busy=%b cnt=%h exp=1/1", busy, redirect_count); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (ctl !== PASS || busy !== 1'b0) begin miscompares++; $display("FAIL mid_stall_reset_ctl ctl=%b busy=%b exp=%b/0", ctl, busy, PASS); end
    vectors++; if (pc_target !== 32'd0 || redirect_count !== 16'd0) begin miscompares++; $display("FAIL mid_stall_reset_regs tgt=%h cnt=%h exp=0/0", pc_target, redirect_count); end
    model_reset();
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
    #1;
    vectors++; if (ctl !== PASS || busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle ctl=%b busy=%b exp=%b/0", ctl, busy, PASS); end
    tick();
  endtask

  task automatic test_count_wrap();
    test_reset();
    for (int i = 0; i < 16; i++) begin
      jump = 1; branch_target = 32'h0000_1000 + 32'(i);
      tick();
      set_idle();
      tick();
      if (i == 14) begin
        #1;
        vectors++; if (s_redirect_count !== 4'hF) begin miscompares++; $display("FAIL wrap_allones got=%h exp=F", s_redirect_count); end
      end
    end
    #1;
    vectors++; if (s_redirect_count !== 4'h0) begin miscompares++; $display("FAIL wrap_zero got=%h exp=0", s_redirect_count); end
    vectors++; if (redirect_count !== 16'd16) begin miscompares++; $display("FAIL wrap_wide got=%h exp=0010", redirect_count); end
  endtask

  task automatic test_random();
    test_reset();
    for (int i = 0; i < 1500; i++) begin
      branch = $urandom_range(0, 1) == 1;
      jump = $urandom_range(0, 4) == 0;
      branch_taken = $urandom_range(0, 1) == 1;
      branch_target = $urandom;
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      ex_regwrite = $urandom_range(0, 1) == 1;
      ex_memread = $urandom_range(0, 1) == 1;
      mem_memread = $urandom_range(0, 1) == 1;
      model_eval();
      #1;
      vectors++; if (ctl !== e_ctl || busy !== e_busy) begin miscompares++; $display("FAIL rand_ctl cyc=%0d ctl=%b busy=%b exp=%b/%b", i, ctl, busy, e_ctl, e_busy); end
      vectors++; if (pc_target !== m_target) begin miscompares++; $display("FAIL rand_target cyc=%0d got=%h exp=%h", i, pc_target, m_target); end
      vectors++; if (redirect_count !== m_count[15:0]) begin miscompares++; $display("FAIL rand_count cyc=%0d got=%h exp=%h", i, redirect_count, m_count[15:0]); end
      vectors++; if (s_redirect_count !== m_count[3:0]) begin miscompares++; $display("FAIL rand_count_small cyc=%0d got=%h exp=%h", i, s_redirect_count, m_count[3:0]); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    model_reset();
    test_reset();
    test_jump();
    test_not_taken();
    test_load_use();
    test_zero_reg();
    test_reset_mid_stall();
    test_count_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
